seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 129 ++++++++++++
 tb/tb_seq_alu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu: operands and opcodes in, registered result and handshake out.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             is_shift;
  logic [1:0]       scode;
  logic [2:0]       acode;
  logic [WIDTH-1:0] R;
  logic             zero;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, carry_in, is_shift, scode, acode,
    input  R, zero, carry_out, busy, done
  );

  modport slave (
    input  start, A, B, carry_in, is_shift, scode, acode,
    output R, zero, carry_out, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops and bit-serial shifts (one position per cycle).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [1:0]       scode_q;
  logic [2:0]       acode_q;
  logic [SHW-1:0]   cnt;
  logic             pend;
  logic [WIDTH-1:0] r_q;
  logic             zero_q;
  logic             cout_q;
  logic             done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH-1:0] sh_res;
  logic             sh_out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum      = '0;
    alu_res  = '0;
    alu_cout = 1'b0;
    case (acode_q)
      3'b000: sum = {1'b0, w} + {1'b0, b_q};
      3'b001: sum = {1'b0, w} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
      3'b010: sum = {1'b0, w} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
      3'b011: sum = {1'b0, w} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, cin_q};
      default: sum = '0;
    endcase
    case (acode_q)
      3'b100:  alu_res = w & b_q;
      3'b101:  alu_res = w | b_q;
      3'b110:  alu_res = w ^ b_q;
      3'b111:  alu_res = ~w;
      default: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
      end
    endcase
  end

  always_comb begin
    sh_res = w;
    sh_out = 1'b0;
    case (scode_q)
      2'b00: begin sh_res = {w[WIDTH-2:0], 1'b0};       sh_out = w[WIDTH-1]; end
      2'b01: begin sh_res = {1'b0, w[WIDTH-1:1]};       sh_out = w[0];       end
      2'b10: begin sh_res = {w[WIDTH-1], w[WIDTH-1:1]}; sh_out = w[0];       end
      default: begin sh_res = {w[WIDTH-2:0], w[WIDTH-1]}; sh_out = w[WIDTH-1]; end
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      w       <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      scode_q <= 2'b00;
      acode_q <= 3'b000;
      cnt     <= '0;
      pend    <= 1'b0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            w       <= bus.A;
            b_q     <= bus.B;
            cin_q   <= bus.carry_in;
            scode_q <= bus.scode;
            acode_q <= bus.acode;
            cnt     <= bus.B[SHW-1:0];
            pend    <= 1'b0;
            state   <= bus.is_shift ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          r_q    <= alu_res;
          zero_q <= (alu_res == '0);
          cout_q <= alu_cout;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        SHIFT: begin
          if (cnt != '0) begin
            w    <= sh_res;
            pend <= sh_out;
            cnt  <= cnt - SHW'(1);
          end else begin
            r_q    <= w;
            zero_q <= (w == '0);
            cout_q <= pend;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.R         = r_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: ALU ops, shifts, back-to-back, zero-shift, mid-op reset.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seq_alu_if #(.WIDTH(8)) bus ();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sh, input logic [1:0] sc, input logic [2:0] ac);
    bus.A = a; bus.B = b; bus.carry_in = cin;
    bus.is_shift = sh; bus.scode = sc; bus.acode = ac;
  endtask

  // Issue one op with a single-cycle start, wait for done, check result and latency.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sh, input logic [1:0] sc,
                        input logic [2:0] ac, input logic [7:0] exp_r,
                        input logic exp_c, input int exp_lat);
    int lat;
    drive(a, b, cin, sh, sc, ac);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_r"},    bus.R, exp_r);
    check({tag, "_cout"}, bus.carry_out, exp_c);
    check({tag, "_zero"}, bus.zero, (exp_r == 8'h00));
    tick();
    check({tag, "_done1"}, bus.done, 1'b0);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000);
    bus.start = 1'b1;
    tick();
    tick();
    check("rst_r",    bus.R, 8'h00);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_cout", bus.carry_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();

    run_op("add", 8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b000, 8'hAC, 1'b1, 1);
    run_op("adc", 8'hE5, 8'hC7, 1'b1, 1'b0, 2'b00, 3'b001, 8'hAD, 1'b1, 1);
    run_op("sub", 8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b010, 8'h1E, 1'b1, 1);
    run_op("sbc", 8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b011, 8'h1D, 1'b1, 1);
    run_op("and", 8'hE5, 8'hC7, 1'b1, 1'b0, 2'b00, 3'b100, 8'hC5, 1'b0, 1);
    run_op("or",  8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b101, 8'hE7, 1'b0, 1);
    run_op("xor", 8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b110, 8'h22, 1'b0, 1);
    run_op("not", 8'hE5, 8'hC7, 1'b0, 1'b0, 2'b00, 3'b111, 8'h1A, 1'b0, 1);
    run_op("sll", 8'hE5, 8'hC7, 1'b0, 1'b1, 2'b00, 3'b000, 8'h80, 1'b0, 8);
    run_op("srl", 8'hE5, 8'hC7, 1'b0, 1'b1, 2'b01, 3'b000, 8'h01, 1'b1, 8);
    run_op("sra", 8'hE5, 8'hC7, 1'b0, 1'b1, 2'b10, 3'b000, 8'hFF, 1'b1, 8);
    run_op("rol", 8'hE5, 8'hC7, 1'b0, 1'b1, 2'b11, 3'b000, 8'hF2, 1'b0, 8);
    run_op("sll2", 8'h81, 8'h02, 1'b0, 1'b1, 2'b00, 3'b000, 8'h04, 1'b0, 3);

    // Back-to-back: start held high through the done cycle.
    drive(8'h5A, 8'h5A, 1'b0, 1'b0, 2'b00, 3'b010);
    bus.start = 1'b1;
    tick();
    tick();
    check("b2b_done", bus.done, 1'b1);
    check("b2b_r",    bus.R, 8'h00);
    check("b2b_zero", bus.zero, 1'b1);
    check("b2b_cout", bus.carry_out, 1'b1);
    check("b2b_busy0", bus.busy, 1'b0);
    drive(8'h01, 8'h02, 1'b0, 1'b0, 2'b00, 3'b000);
    tick();
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_nodone", bus.done, 1'b0);
    bus.start = 1'b0;
    tick();
    check("b2b2_done", bus.done, 1'b1);
    check("b2b2_r",    bus.R, 8'h03);
    check("b2b2_zero", bus.zero, 1'b0);
    tick();

    // Zero shift amount; start kept high with new operands while busy must be ignored.
    drive(8'h81, 8'h00, 1'b0, 1'b1, 2'b11, 3'b000);
    bus.start = 1'b1;
    tick();
    check("sh0_busy", bus.busy, 1'b1);
    drive(8'hFF, 8'h07, 1'b1, 1'b1, 2'b00, 3'b000);
    tick();
    bus.start = 1'b0;
    check("sh0_done", bus.done, 1'b1);
    check("sh0_r",    bus.R, 8'h81);
    check("sh0_cout", bus.carry_out, 1'b0);
    tick();
    check("sh0_idle", bus.busy, 1'b0);
    check("sh0_done1", bus.done, 1'b0);

    // Reset in the middle of a 7-step shift.
    drive(8'hE5, 8'h07, 1'b0, 1'b1, 2'b00, 3'b000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_done", bus.done, 1'b0);
    check("mrst_r",    bus.R, 8'h00);
    check("mrst_zero", bus.zero, 1'b0);
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    check("mrst_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
